// File: rtl/tcdm_rmw_responder_pkg.sv
// Shared types and helpers for the TCDM bank responder: FSM states, bus widths
// and the byte-lane merge used by partial-word read-modify-write.
package tcdm_rmw_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  localparam int TCDM_DATA_WIDTH = 32;
  localparam int TCDM_BE_WIDTH   = 4;

  // Enabled lanes take the new data, disabled lanes keep the word read from SRAM.
  function automatic logic [TCDM_DATA_WIDTH-1:0] byte_merge(
    input logic [TCDM_DATA_WIDTH-1:0] old_w,
    input logic [TCDM_DATA_WIDTH-1:0] new_w,
    input logic [TCDM_BE_WIDTH-1:0]   be
  );
    logic [TCDM_DATA_WIDTH-1:0] merged;
    merged = old_w;
    for (int b = 0; b < TCDM_BE_WIDTH; b++) begin
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tcdm_rmw_responder.sv
// Bank-side TCDM responder for a single-port SRAM without byte enables.
// Responses come exactly one cycle after grant; partial writes take an extra read cycle.
module tcdm_rmw_responder
  import tcdm_rmw_responder_pkg::*;
#(
  parameter int          NR_BANKS       = 4,
  parameter int          MEM_ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [31:0]                add_i,
  input  logic                       wen_i,
  input  logic [31:0]                wdata_i,
  input  logic [3:0]                 be_i,
  output logic                       gnt_o,
  output logic                       r_valid_o,
  output logic [31:0]                r_rdata_o,
  output logic                       r_opc_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [31:0]                mem_rdata_i
);

  localparam int          ADDR_LSB     = 2 + $clog2(NR_BANKS);
  localparam int          ADDR_TAG_LSB = ADDR_LSB + MEM_ADDR_WIDTH;
  localparam logic [31:0] REGION_BYTES = 32'(NR_BANKS * 4) << MEM_ADDR_WIDTH;

  if ((NR_BANKS < 1) || ((NR_BANKS & (NR_BANKS - 1)) != 0)) begin : g_bad_banks
    $error("NR_BANKS must be a power of two");
  end
  if ((BASE_ADDR & (REGION_BYTES - 32'd1)) != 32'd0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to the interleaved region size");
  end

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TCDM_BE_WIDTH-1:0]  be_q, be_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      rvalid_q, ropc_q, rsel_q;
  logic                      resp_opc, resp_rd;

  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic                      in_range;
  logic                      unused_addr_bits;

  assign word_idx         = add_i[ADDR_LSB +: MEM_ADDR_WIDTH];
  assign in_range         = (add_i[31:ADDR_TAG_LSB] == BASE_ADDR[31:ADDR_TAG_LSB]);
  assign unused_addr_bits = ^add_i[ADDR_LSB-1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    resp_opc    = 1'b0;
    resp_rd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (!in_range) begin
            gnt_o    = 1'b1;
            resp_opc = 1'b1;
          end else if (wen_i) begin
            gnt_o      = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = word_idx;
            resp_rd    = 1'b1;
          end else if (be_i == 4'hF) begin
            gnt_o       = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = word_idx;
            mem_wdata_o = wdata_i;
          end else if (be_i == 4'h0) begin
            gnt_o = 1'b1;
          end else begin
            // Grant is withheld until the old word is back from SRAM.
            mem_req_o  = 1'b1;
            mem_addr_o = word_idx;
            addr_d     = word_idx;
            be_d       = be_i;
            wdata_d    = wdata_i;
            state_d    = MERGE;
          end
        end
      end
      MERGE: begin
        // The latched payload drives the write; req_i is deliberately ignored.
        gnt_o       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = byte_merge(mem_rdata_i, wdata_q, be_q);
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      ropc_q   <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= gnt_o;
      ropc_q   <= resp_opc;
      rsel_q   <= resp_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  // Read data is a gated pass-through of the SRAM output, which lands one cycle after the read.
  assign r_valid_o = rvalid_q;
  assign r_opc_o   = ropc_q;
  assign r_rdata_o = (rvalid_q && rsel_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_tcdm_rmw_responder.sv
// Self-checking bench for tcdm_rmw_responder: a per-transaction model predicts grant,
// SRAM traffic and the response; a negedge process compares every cycle.
module tb_tcdm_rmw_responder;

  localparam int          NB     = 4;
  localparam int          AW     = 12;
  localparam int          WORDS  = 1 << AW;
  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam logic [31:0] REGION = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic [31:0]   add_i = '0;
  logic          wen_i = 1'b0;
  logic [31:0]   wdata_i = '0;
  logic [3:0]    be_i = '0;
  logic          gnt_o, r_valid_o, r_opc_o, mem_req_o, mem_we_o;
  logic [31:0]   r_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_rdata_i = '0;

  logic [31:0] sram  [0:WORDS-1];
  logic [31:0] model [0:WORDS-1];

  int nvec = 0;
  int nerr = 0;

  // Expectations for the current cycle and the response due next cycle.
  logic          e_gnt = 0, e_mreq = 0, e_mwe = 0, e_rv = 0, e_opc = 0;
  logic [AW-1:0] e_maddr = '0;
  logic [31:0]   e_mwdata = '0, e_rd = '0;
  logic          n_rv = 0, n_opc = 0;
  logic [31:0]   n_rd = '0;

  tcdm_rmw_responder #(
    .NR_BANKS(NB), .MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i      <= sram[mem_addr_o];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("gnt",       32'(gnt_o),       32'(e_gnt));
    check("r_valid",   32'(r_valid_o),   32'(e_rv));
    check("r_opc",     32'(r_opc_o),     32'(e_opc));
    check("r_rdata",   r_rdata_o,        e_rd);
    check("mem_req",   32'(mem_req_o),   32'(e_mreq));
    check("mem_we",    32'(mem_we_o),    32'(e_mwe));
    check("mem_addr",  32'(mem_addr_o),  32'(e_maddr));
    check("mem_wdata", mem_wdata_o,      e_mwdata);
  end

  function automatic logic oor_f(input logic [31:0] a);
    return !((a >= BASE) && (a < BASE + REGION));
  endfunction

  function automatic int idx_f(input logic [31:0] a);
    return int'(((a - BASE) / (4 * NB)) % WORDS);
  endfunction

  function automatic logic [31:0] merge_f(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    e_rv = n_rv; e_opc = n_opc; e_rd = n_rd;
    n_rv = 0; n_opc = 0; n_rd = '0;
    e_gnt = 0; e_mreq = 0; e_mwe = 0; e_maddr = '0; e_mwdata = '0;
    req_i = 0; wen_i = 0; add_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic txn(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be);
    logic        oor;
    int          ix;
    logic [31:0] m;
    oor = oor_f(a);
    ix  = idx_f(a);
    step();
    req_i = 1; wen_i = rd; add_i = a; wdata_i = wd; be_i = be;
    if (oor) begin
      e_gnt = 1; n_rv = 1; n_opc = 1;
    end else if (rd) begin
      e_gnt = 1; e_mreq = 1; e_maddr = AW'(ix); n_rv = 1; n_rd = model[ix];
    end else if (be == 4'hF) begin
      e_gnt = 1; e_mreq = 1; e_mwe = 1; e_maddr = AW'(ix); e_mwdata = wd;
      model[ix] = wd; n_rv = 1;
    end else if (be == 4'h0) begin
      e_gnt = 1; n_rv = 1;
    end else begin
      e_mreq = 1; e_maddr = AW'(ix);
      step();
      req_i = 1; wen_i = rd; add_i = a; wdata_i = wd; be_i = be;
      m = merge_f(model[ix], wd, be);
      model[ix] = m;
      e_gnt = 1; e_mreq = 1; e_mwe = 1; e_maddr = AW'(ix); e_mwdata = m; n_rv = 1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] word3_before;
    for (int i = 0; i < WORDS; i++) begin
      sram[i]  = 32'(i) * 32'h9E37_79B9;
      model[i] = 32'(i) * 32'h9E37_79B9;
    end

    repeat (3) step();
    rst_ni = 1'b1;
    repeat (10) step();

    // Full write then read of word index 1.
    txn(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    txn(1'b1, BASE + 32'h10, 32'h0, 4'h0);
    step();
    @(negedge clk);
    check("lit_read_full", r_rdata_o, 32'hDEAD_BEEF);

    // Partial write of the low half, then read back.
    txn(1'b0, BASE + 32'h10, 32'h0000_1234, 4'b0011);
    txn(1'b1, BASE + 32'h10, 32'h0, 4'h0);
    step();
    @(negedge clk);
    check("lit_read_merged", r_rdata_o, 32'hDEAD_1234);
    check("lit_model_merged", model[1], 32'hDEAD_1234);
    check("lit_sram_merged", sram[1], 32'hDEAD_1234);

    // Address error, then a be=0 write no-op.
    txn(1'b1, BASE + REGION, 32'h0, 4'h0);
    step();
    @(negedge clk);
    check("lit_err_opc", 32'(r_opc_o), 32'd1);
    check("lit_err_rdata", r_rdata_o, 32'h0);
    txn(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0);
    step();

    // Back-to-back read, partial write, read.
    txn(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    txn(1'b0, BASE + 32'h20, 32'h00AB_0000, 4'b0100);
    txn(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    step();
    step();

    // Reset asserted during the MERGE cycle.
    word3_before = model[3];
    step();
    req_i = 1; wen_i = 0; add_i = BASE + 32'h30; wdata_i = 32'hFFFF_FFFF; be_i = 4'b1000;
    e_mreq = 1; e_maddr = AW'(3);
    step();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
    txn(1'b1, BASE + 32'h30, 32'h0, 4'h0);
    step();
    @(negedge clk);
    check("lit_rst_abort", r_rdata_o, word3_before);

    // Randomised mix over a small set of words so reads often hit recent writes.
    for (int t = 0; t < 400; t++) begin
      a = BASE + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = a ^ (32'h1 << $urandom_range(16, 31));
      txn(($urandom_range(0, 9) < 4), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) step();
    end
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
